// File: rtl/apb_rr_arb.sv
// apb_rr_arb: round-robin arbiter in front of a single APB master port.
// Up to NUM_REQ requesters present commands. In IDLE one of them is chosen
// in round-robin order and its command is run as a SETUP/ACCESS transfer.
// The response goes back to that requester as a one-cycle rsp_valid pulse.
// A transfer whose slave stalls too long is aborted with rsp_err set.
module apb_rr_arb #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                                apb_pclk,
    input  logic                                apb_prstn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]           rsp_rdata,
    output logic                                rsp_err,
    output logic                                apb_psel,
    output logic                                apb_penable,
    output logic                                apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]           apb_paddr,
    output logic [APB_DATA_WIDTH-1:0]           apb_pwdata,
    input  logic                                apb_pready,
    input  logic [APB_DATA_WIDTH-1:0]           apb_prdata
);

    // Width of a requester index; NUM_REQ is at least 2 so this is >= 1.
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Timeout limit held in the same width as the stall counter.
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    // After reset the last grant points at the top requester, so the
    // round-robin search starts at requester 0.
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Arbitration state and stall counter
    logic [GW-1:0]             last_grant_reg;
    logic [GW-1:0]             last_grant_next;
    logic [7:0]                cnt_reg;
    logic [7:0]                cnt_next;

    // Registered APB master outputs
    logic                      psel_reg;
    logic                      psel_next;
    logic                      penable_reg;
    logic                      penable_next;
    logic                      pwrite_reg;
    logic                      pwrite_next;
    logic [APB_ADDR_WIDTH-1:0] paddr_reg;
    logic [APB_ADDR_WIDTH-1:0] paddr_next;
    logic [APB_DATA_WIDTH-1:0] pwdata_reg;
    logic [APB_DATA_WIDTH-1:0] pwdata_next;

    // Registered response outputs
    logic [NUM_REQ-1:0]        rsp_valid_reg;
    logic [NUM_REQ-1:0]        rsp_valid_next;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_reg;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_next;
    logic                      rsp_err_reg;
    logic                      rsp_err_next;

    // Per-requester views of the packed command buses
    logic [APB_ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [APB_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    // Round-robin selection results
    logic [GW-1:0]             sel_idx;
    logic                      sel_found;
    logic [NUM_REQ-1:0]        sel_onehot;
    logic [NUM_REQ-1:0]        grant_onehot;

    logic                      timeout_hit;

    // Unpack the command buses and build one-hot decodes of the selected
    // requester and of the requester that owns the transfer in flight.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            assign wdata_arr[gi]    = req_wdata[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            assign sel_onehot[gi]   = sel_found && (sel_idx == GW'(gi));
            assign grant_onehot[gi] = (last_grant_reg == GW'(gi));
        end
    endgenerate

    // The stall counter has reached its limit; only acted on in ACCESS.
    assign timeout_hit = (cnt_reg == TO_LIMIT);

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        sel_idx   = last_grant_reg;
        sel_found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant_reg) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(cand);
            end
        end
    end

    // State register: reset abandons any transfer in flight.
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> SETUP on a grant, SETUP lasts one cycle,
    // ACCESS ends on pready or on the stall limit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_found) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_pready || timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: combinational accept, plus next values for every
    // registered output. pready has priority over the timeout abort.
    always_comb begin
        req_ready       = '0;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        psel_next       = psel_reg;
        penable_next    = penable_reg;
        pwrite_next     = pwrite_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        rsp_valid_next  = '0;
        rsp_rdata_next  = rsp_rdata_reg;
        rsp_err_next    = rsp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                req_ready = sel_onehot;
                if (sel_found) begin
                    last_grant_next = sel_idx;
                    psel_next       = 1'b1;
                    penable_next    = 1'b0;
                    pwrite_next     = req_write[sel_idx];
                    paddr_next      = addr_arr[sel_idx];
                    pwdata_next     = wdata_arr[sel_idx];
                end
            end
            ST_SETUP: begin
                penable_next = 1'b1;
                cnt_next     = '0;
            end
            ST_ACCESS: begin
                if (apb_pready) begin
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = grant_onehot;
                    rsp_rdata_next = pwrite_reg ? '0 : apb_prdata;
                    rsp_err_next   = 1'b0;
                end else if (timeout_hit) begin
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = grant_onehot;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    // Datapath registers: APB outputs, response outputs, grant and counter.
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            last_grant_reg <= LAST_INIT;
            cnt_reg        <= '0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            pwrite_reg     <= pwrite_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_err_reg    <= rsp_err_next;
        end
    end

    assign apb_psel    = psel_reg;
    assign apb_penable = penable_reg;
    assign apb_pwrite  = pwrite_reg;
    assign apb_paddr   = paddr_reg;
    assign apb_pwdata  = pwdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_apb_rr_arb.sv
// tb_apb_rr_arb: directed and randomized checks of apb_rr_arb against a
// transaction-level model (round-robin pick, expected stall length,
// expected response data and error flag).
module tb_apb_rr_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              apb_pclk = 1'b0;
    logic              apb_prstn = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [AW-1:0]     apb_paddr;
    logic [DW-1:0]     apb_pwdata;
    logic              apb_pready = 1'b0;
    logic [DW-1:0]     apb_prdata = '0;

    apb_rr_arb #(
        .NUM_REQ        (N),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) dut (
        .apb_pclk    (apb_pclk),
        .apb_prstn   (apb_prstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_pready  (apb_pready),
        .apb_prdata  (apb_prdata)
    );

    always #5 apb_pclk = ~apb_pclk;

    int            n_vec = 0;
    int            n_err = 0;
    int            last_g_m = N - 1;
    logic [DW-1:0] last_rd_m = '0;
    logic          last_err_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: first valid requester after the previous grant, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]        = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One full transfer. Entered at a negedge in IDLE with inputs driven;
    // leaves at the negedge of the response cycle. The slave raises pready
    // after 'waits' stalled ACCESS cycles.
    task automatic xfer(input int waits, input logic [DW-1:0] rd, input string tag);
        int            g;
        int            acc;
        int            exp_acc;
        logic          w;
        logic          exp_err;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        #1;
        g = rr_pick(req_valid, last_g_m);
        if (g < 0) begin
            n_err++;
            $display("FAIL %s: no valid requester driven", tag);
            return;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'(1 << g));
        w = req_write[g];
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        @(negedge apb_pclk);
        last_g_m = g;
        chk({tag, "_setup_psel"}, 64'(apb_psel), 64'd1);
        chk({tag, "_setup_penable"}, 64'(apb_penable), 64'd0);
        chk({tag, "_pwrite"}, 64'(apb_pwrite), 64'(w));
        chk({tag, "_paddr"}, 64'(apb_paddr), 64'(a));
        chk({tag, "_pwdata"}, 64'(apb_pwdata), 64'(d));
        chk({tag, "_ready_low"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_idle"}, 64'(rsp_valid), 64'd0);
        @(negedge apb_pclk);
        chk({tag, "_access_penable"}, 64'(apb_penable), 64'd1);
        acc = 0;
        while (apb_psel === 1'b1 && acc < 64) begin
            acc++;
            apb_pready = (acc > waits);
            apb_prdata = rd;
            chk({tag, "_paddr_hold"}, 64'(apb_paddr), 64'(a));
            chk({tag, "_penable_hold"}, 64'(apb_penable), 64'd1);
            @(negedge apb_pclk);
        end
        apb_pready = 1'b0;
        apb_prdata = $urandom;
        exp_err = (waits > TO);
        exp_acc = exp_err ? TO + 1 : waits + 1;
        exp_rd  = (exp_err || w) ? '0 : rd;
        chk({tag, "_access_cycles"}, 64'(acc), 64'(exp_acc));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1 << g));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        chk({tag, "_psel_drop"}, 64'(apb_psel), 64'd0);
        chk({tag, "_penable_drop"}, 64'(apb_penable), 64'd0);
        last_rd_m  = exp_rd;
        last_err_m = exp_err;
        $display("xfer %s: req=%0d %s addr=%h waits=%0d access=%0d err=%0d rdata=%h",
                 tag, g, w ? "WR" : "RD", a, waits, acc, rsp_err, rsp_rdata);
    endtask

    // Idle with no requests: nothing issues and response fields hold.
    task automatic idle(input int n, input string tag);
        req_valid = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge apb_pclk);
            chk({tag, "_idle_rsp_valid"}, 64'(rsp_valid), 64'd0);
            chk({tag, "_idle_psel"}, 64'(apb_psel), 64'd0);
            chk({tag, "_idle_rdata_hold"}, 64'(rsp_rdata), 64'(last_rd_m));
            chk({tag, "_idle_err_hold"}, 64'(rsp_err), 64'(last_err_m));
        end
    endtask

    initial begin
        // Reset state
        @(negedge apb_pclk);
        @(negedge apb_pclk);
        chk("rst_psel", 64'(apb_psel), 64'd0);
        chk("rst_penable", 64'(apb_penable), 64'd0);
        chk("rst_pwrite", 64'(apb_pwrite), 64'd0);
        chk("rst_paddr", 64'(apb_paddr), 64'd0);
        chk("rst_pwdata", 64'(apb_pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        apb_prstn = 1'b1;
        idle(1, "post_rst");

        // Single write from requester 2, zero-wait slave
        set_req(2, 1'b1, 32'h40, 32'hA5A5_0001);
        req_valid = 4'b0100;
        xfer(0, 32'hDEAD_BEEF, "wr_req2");
        idle(2, "wr_req2");

        // Read from requester 1 with three stall cycles
        set_req(1, 1'b0, 32'h100, 32'h0);
        req_valid = 4'b0010;
        xfer(3, 32'h1234_5678, "rd_req1_wait3");
        idle(1, "rd_req1_wait3");

        // pready arrives exactly on the timeout cycle: data returned, no error
        set_req(0, 1'b0, 32'h200, 32'h0);
        req_valid = 4'b0001;
        xfer(TO, 32'hCAFE_F00D, "rd_req0_edge");
        idle(1, "rd_req0_edge");

        // pready never arrives: abort with error after TIMEOUT+1 ACCESS cycles
        set_req(3, 1'b0, 32'h300, 32'h0);
        req_valid = 4'b1000;
        xfer(100, 32'h5555_AAAA, "rd_req3_timeout");
        idle(1, "rd_req3_timeout");

        // All four requesters held valid: rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < N; i++) set_req(i, i[0], 32'(32'h1000 + i * 4), 32'($urandom));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_all_order", 64'(req_ready), 64'(1 << (k % N)));
            xfer(0, 32'($urandom), "rr_all");
        end
        idle(1, "rr_all");

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 32'($urandom), 32'($urandom));
            req_valid = 4'($urandom_range(1, 15));
            xfer($urandom_range(0, 6), 32'($urandom), "rand");
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), "rand");
        end
        idle(1, "rand_end");

        // Reset in the middle of ACCESS abandons the transfer
        set_req(1, 1'b0, 32'h500, 32'h0);
        req_valid = 4'b0010;
        @(negedge apb_pclk);
        @(negedge apb_pclk);
        apb_pready = 1'b0;
        @(negedge apb_pclk);
        chk("mid_rst_in_access", 64'(apb_penable), 64'd1);
        #2;
        apb_prstn = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_psel", 64'(apb_psel), 64'd0);
        chk("mid_rst_penable", 64'(apb_penable), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        last_g_m   = N - 1;
        last_rd_m  = '0;
        last_err_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge apb_pclk);
            chk("mid_rst_hold_rsp", 64'(rsp_valid), 64'd0);
            chk("mid_rst_hold_psel", 64'(apb_psel), 64'd0);
        end
        apb_prstn = 1'b1;
        set_req(0, 1'b1, 32'h600, 32'h0000_0600);
        set_req(3, 1'b1, 32'h700, 32'h0000_0700);
        req_valid = 4'b1001;
        xfer(0, 32'h0, "post_rst_req0");
        xfer(1, 32'h0, "post_rst_req3");
        idle(2, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
